// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one unified RAM port between instruction fetch
// (16-bit parcels) and data load/store (32-bit words). Data has priority,
// but fetch is forced through after DATA_MAX consecutive data grants.
// One access is granted per cycle and its response appears one cycle later.
module mem_arbiter #(
    parameter int AW       = 32,
    parameter int DATA_MAX = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_f_req,
    input  logic [AW-1:0] i_f_addr,
    output logic          o_f_gnt,
    output logic          o_f_ack,
    output logic [15:0]   o_f_data,
    input  logic          i_d_req,
    input  logic          i_d_write,
    input  logic [AW-1:0] i_d_addr,
    input  logic [31:0]   i_d_wdata,
    output logic          o_d_gnt,
    output logic          o_d_ack,
    output logic [31:0]   o_d_rdata,
    output logic          o_fault,
    output logic [1:0]    o_ram_action,
    output logic [AW-1:0] o_ram_addr,
    output logic [31:0]   o_ram_val,
    input  logic [31:0]   i_ram_out
);

    localparam logic [3:0] CNT_MAX = 4'(DATA_MAX);

    localparam logic [1:0] ACT_NONE  = 2'b00;
    localparam logic [1:0] ACT_READ  = 2'b01;
    localparam logic [1:0] ACT_WRITE = 2'b10;

    logic [3:0] starve_cnt;
    logic       f_win;
    logic       d_win;
    logic       f_mis;
    logic       d_mis;

    // In-flight tag: what was granted last cycle and how to shape its response.
    logic       fl_f;
    logic       fl_d;
    logic       fl_hsel;
    logic       fl_store;
    logic       fl_mis;
    logic       fault_r;

    // Arbitration: data first unless fetch has waited DATA_MAX data grants.
    always_comb begin
        f_mis = i_f_addr[0];
        d_mis = (i_d_addr[1:0] != 2'b00);
        f_win = 1'b0;
        d_win = 1'b0;
        if (i_rst) begin
            f_win = 1'b0;
            d_win = 1'b0;
        end else if (i_f_req && (!i_d_req || starve_cnt == CNT_MAX)) begin
            f_win = 1'b1;
        end else if (i_d_req) begin
            d_win = 1'b1;
        end else begin
            f_win = 1'b0;
            d_win = 1'b0;
        end
    end

    assign o_f_gnt = f_win;
    assign o_d_gnt = d_win;

    // RAM issue on the grant cycle; misaligned accesses never touch the RAM.
    always_comb begin
        o_ram_action = ACT_NONE;
        o_ram_addr   = '0;
        o_ram_val    = 32'h0000_0000;
        if (f_win) begin
            o_ram_addr = {i_f_addr[AW-1:2], 2'b00};
            if (!f_mis) begin
                o_ram_action = ACT_READ;
            end else begin
                o_ram_action = ACT_NONE;
            end
        end else if (d_win) begin
            o_ram_addr = {i_d_addr[AW-1:2], 2'b00};
            o_ram_val  = i_d_wdata;
            if (d_mis) begin
                o_ram_action = ACT_NONE;
            end else if (i_d_write) begin
                o_ram_action = ACT_WRITE;
            end else begin
                o_ram_action = ACT_READ;
            end
        end else begin
            o_ram_action = ACT_NONE;
        end
    end

    // Starvation counter: counts data grants taken while fetch is waiting.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            starve_cnt <= 4'd0;
        end else if (f_win || !i_f_req) begin
            starve_cnt <= 4'd0;
        end else if (d_win && (starve_cnt != CNT_MAX)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end else begin
            starve_cnt <= starve_cnt;
        end
    end

    // In-flight tag and sticky fault capture for next-cycle responses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fl_f     <= 1'b0;
            fl_d     <= 1'b0;
            fl_hsel  <= 1'b0;
            fl_store <= 1'b0;
            fl_mis   <= 1'b0;
            fault_r  <= 1'b0;
        end else begin
            fl_f     <= f_win;
            fl_d     <= d_win;
            fl_hsel  <= i_f_addr[1];
            fl_store <= i_d_write;
            fl_mis   <= (f_win && f_mis) || (d_win && d_mis);
            fault_r  <= fault_r || (f_win && f_mis) || (d_win && d_mis);
        end
    end

    assign o_f_ack = fl_f && !i_rst;
    assign o_d_ack = fl_d && !i_rst;
    assign o_fault = fault_r && !i_rst;

    // Response shaping: halfword select for fetch, zero for stores/misaligned.
    always_comb begin
        o_f_data  = 16'h0000;
        o_d_rdata = 32'h0000_0000;
        if (o_f_ack && !fl_mis) begin
            o_f_data = fl_hsel ? i_ram_out[31:16] : i_ram_out[15:0];
        end else begin
            o_f_data = 16'h0000;
        end
        if (o_d_ack && !fl_mis && !fl_store) begin
            o_d_rdata = i_ram_out;
        end else begin
            o_d_rdata = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a RAM environment, a spec-level
// reference model checked every cycle, and directed literal expectations.
module tb_mem_arbiter;

    localparam int AW       = 32;
    localparam int DATA_MAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_gnt, f_ack;
    logic [15:0]   f_data;
    logic          d_req, d_write;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic          d_gnt, d_ack;
    logic [31:0]   d_rdata;
    logic          fault;
    logic [1:0]    ram_action;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_val;
    logic [31:0]   ram_out;

    int checks   = 0;
    int failures = 0;
    logic ready = 1'b0;

    logic [31:0] ram    [64];
    logic [31:0] shadow [64];

    int          m_cnt;
    int          m_pend;
    logic [31:0] m_pdata;
    logic        m_fault;

    mem_arbiter #(.AW(AW), .DATA_MAX(DATA_MAX)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_f_req(f_req), .i_f_addr(f_addr), .o_f_gnt(f_gnt), .o_f_ack(f_ack), .o_f_data(f_data),
        .i_d_req(d_req), .i_d_write(d_write), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
        .o_d_gnt(d_gnt), .o_d_ack(d_ack), .o_d_rdata(d_rdata), .o_fault(fault),
        .o_ram_action(ram_action), .o_ram_addr(ram_addr), .o_ram_val(ram_val),
        .i_ram_out(ram_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // RAM environment: reads return one cycle later, writes commit at the edge.
    always @(posedge clk) begin
        if (ram_action == 2'b01) ram_out <= ram[ram_addr[7:2]];
        else if (ram_action == 2'b10) ram[ram_addr[7:2]] <= ram_val;
    end

    // Reference model: compare this cycle's outputs, then advance model state.
    always @(negedge clk) begin
        logic        ef, ed, fmis, dmis;
        logic [1:0]  eact;
        logic [31:0] eaddr;
        ef    = !rst && f_req && (!d_req || m_cnt == DATA_MAX);
        ed    = !rst && d_req && !ef;
        fmis  = f_addr[0];
        dmis  = (d_addr[1:0] != 2'b00);
        eact  = ef ? (fmis ? 2'b00 : 2'b01)
              : ed ? (dmis ? 2'b00 : (d_write ? 2'b10 : 2'b01)) : 2'b00;
        eaddr = ef ? (f_addr & ~32'd3) : (d_addr & ~32'd3);
        if (ready) begin
            chk("m_f_gnt", f_gnt, ef);
            chk("m_d_gnt", d_gnt, ed);
            chk("m_action", ram_action, eact);
            if (eact != 2'b00) chk("m_addr", ram_addr, eaddr);
            if (eact == 2'b10) chk("m_val", ram_val, d_wdata);
            chk("m_f_ack", f_ack, (m_pend == 1) && !rst);
            chk("m_d_ack", d_ack, (m_pend == 2) && !rst);
            if ((m_pend == 1) && !rst) chk("m_f_data", f_data, m_pdata[15:0]);
            if ((m_pend == 2) && !rst) chk("m_d_rdata", d_rdata, m_pdata);
            chk("m_fault", fault, m_fault && !rst);
        end
        if (rst) begin
            m_cnt   = 0;
            m_pend  = 0;
            m_pdata = 32'h0;
            m_fault = 1'b0;
        end else begin
            m_pend  = ef ? 1 : (ed ? 2 : 0);
            m_pdata = 32'h0;
            if (ef && !fmis)
                m_pdata = {16'h0, f_addr[1] ? shadow[f_addr[7:2]][31:16] : shadow[f_addr[7:2]][15:0]};
            if (ed && !dmis && !d_write) m_pdata = shadow[d_addr[7:2]];
            if ((ef && fmis) || (ed && dmis)) m_fault = 1'b1;
            if (ef || !f_req) m_cnt = 0;
            else if (ed && m_cnt < DATA_MAX) m_cnt = m_cnt + 1;
            if (ed && !dmis && d_write) shadow[d_addr[7:2]] = d_wdata;
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            ram[i]    = 32'h1000_0000 + 32'(i);
            shadow[i] = 32'h1000_0000 + 32'(i);
        end
        ram[0] = 32'hBBBB_AAAA; shadow[0] = 32'hBBBB_AAAA;
        ram[1] = 32'hDDDD_CCCC; shadow[1] = 32'hDDDD_CCCC;
        ram_out = 32'h0;
        rst = 1'b1; f_req = 1'b0; f_addr = 32'h0;
        d_req = 1'b0; d_write = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;

        // Reset state
        step; step;
        ready = 1'b1;
        @(negedge clk);
        chk("rst_f_ack", f_ack, 1'b0);
        chk("rst_d_ack", d_ack, 1'b0);
        chk("rst_fault", fault, 1'b0);
        chk("rst_action", ram_action, 2'b00);

        // Back-to-back fetch 0x0, 0x2, 0x4
        step; rst = 1'b0; f_req = 1'b1; f_addr = 32'h0;
        @(negedge clk);
        chk("fe0_gnt", f_gnt, 1'b1);
        chk("fe0_action", ram_action, 2'b01);
        step; f_addr = 32'h2;
        @(negedge clk);
        chk("fe1_ack", f_ack, 1'b1);
        chk("fe1_data", f_data, 16'hAAAA);
        step; f_addr = 32'h4;
        @(negedge clk);
        chk("fe2_data", f_data, 16'hBBBB);
        step; f_req = 1'b0;
        @(negedge clk);
        chk("fe3_data", f_data, 16'hCCCC);

        // Store then load at 0x10
        step; d_req = 1'b1; d_write = 1'b1; d_addr = 32'h10; d_wdata = 32'h1234_5678;
        @(negedge clk);
        chk("st_action", ram_action, 2'b10);
        chk("st_addr", ram_addr, 32'h10);
        chk("st_val", ram_val, 32'h1234_5678);
        step; d_write = 1'b0;
        @(negedge clk);
        chk("ld_action", ram_action, 2'b01);
        chk("st_ack", d_ack, 1'b1);
        chk("st_rdata", d_rdata, 32'h0);
        step; d_req = 1'b0;
        @(negedge clk);
        chk("ld_ack", d_ack, 1'b1);
        chk("ld_rdata", d_rdata, 32'h1234_5678);

        // Both held: D,D,D,D,F repeating
        step; f_req = 1'b1; f_addr = 32'h8; d_req = 1'b1; d_write = 1'b0; d_addr = 32'h14;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) step;
            @(negedge clk);
            chk("pat_f_gnt", f_gnt, (i % 5) == 4);
            chk("pat_d_gnt", d_gnt, (i % 5) != 4);
        end
        step; f_req = 1'b0; d_req = 1'b0;

        // Misaligned fetch 0x3
        step; f_req = 1'b1; f_addr = 32'h3;
        @(negedge clk);
        chk("mf_gnt", f_gnt, 1'b1);
        chk("mf_action", ram_action, 2'b00);
        step; f_req = 1'b0;
        @(negedge clk);
        chk("mf_ack", f_ack, 1'b1);
        chk("mf_data", f_data, 16'h0);
        chk("mf_fault", fault, 1'b1);
        step; step;
        @(negedge clk);
        chk("mf_sticky", fault, 1'b1);

        // Load granted at N, reset at N+1 and N+2, request held across release
        step; d_req = 1'b1; d_write = 1'b0; d_addr = 32'h10;
        @(negedge clk);
        chk("rl_gnt", d_gnt, 1'b1);
        step; rst = 1'b1;
        @(negedge clk);
        chk("rl_ack_n1", d_ack, 1'b0);
        chk("rl_gnt_rst", d_gnt, 1'b0);
        chk("rl_fault_rst", fault, 1'b0);
        step;
        @(negedge clk);
        chk("rl_ack_n2", d_ack, 1'b0);
        step; rst = 1'b0;
        @(negedge clk);
        chk("rl_regnt", d_gnt, 1'b1);
        chk("rl_no_ack", d_ack, 1'b0);
        step; d_req = 1'b0;
        @(negedge clk);
        chk("rl_ack", d_ack, 1'b1);
        chk("rl_rdata", d_rdata, 32'h1234_5678);
        chk("rl_fault_clr", fault, 1'b0);

        // Misaligned store must not write RAM
        step; d_req = 1'b1; d_write = 1'b1; d_addr = 32'h21; d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("ms_action", ram_action, 2'b00);
        step; d_write = 1'b0; d_addr = 32'h20;
        @(negedge clk);
        chk("ms_ack", d_ack, 1'b1);
        chk("ms_rdata", d_rdata, 32'h0);
        chk("ms_fault", fault, 1'b1);
        step; d_req = 1'b0;
        @(negedge clk);
        chk("ms_unwritten", d_rdata, 32'h1000_0008);

        step; step;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
